// File: rtl/edge_arb_pkg.sv
// Shared types and the round-robin winner search for the edge event arbiter.
package edge_arb_pkg;

  localparam int MAXN = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set bit of pend at or after ptr, wrapping modulo n; returns ptr when nothing is pending.
  function automatic logic [3:0] rr_winner(input logic [MAXN-1:0] pend,
                                           input logic [3:0]      ptr,
                                           input int              n);
    int idx;
    rr_winner = ptr;
    for (int k = MAXN - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (pend[idx[3:0]]) rr_winner = idx[3:0];
      end
    end
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Grant handshake between the arbiter (master) and the event consumer (slave).
interface edge_event_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic           o_valid;
  logic [N-1:0]   o_gnt;
  logic [IDW-1:0] o_id;
  logic           in_ack;

  modport master (output o_valid, output o_gnt, output o_id, input in_ack);
  modport slave  (input o_valid, input o_gnt, input o_id, output in_ack);
endinterface

// File: rtl/edge_event_arbiter_rise_sampler.sv
// Per-channel rising-edge detector; prev resets to ones so lines high at reset release are not events.
module rise_sampler #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '1;
    else       prev_q <= req_i;
  end

  assign rise_o = req_i & ~prev_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Sticky per-channel pending flags served one at a time by a round-robin grant FSM.
// Grant appears two clocks after the edge; one idle clock separates consecutive grants.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [N-1:0]         in_req,
  input  logic                 in_clr_ovf,
  edge_event_arbiter_if.master evt,
  output logic [N-1:0]         o_pend,
  output logic [N-1:0]         o_ovf
);

  state_e         state_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   ovf_q, ovf_d;
  logic [N-1:0]   gnt_q;
  logic [N-1:0]   clr_vec;
  logic [IDW-1:0] gnt_id_q, ptr_q, win;
  logic           valid_q;
  logic           ack_fire;

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  rise_sampler #(.N(N)) u_rise (
    .clk_i  (in_clk),
    .rst_i  (in_rst),
    .req_i  (in_req),
    .rise_o (rise)
  );

  assign win = IDW'(rr_winner(MAXN'(pend_q), 4'(ptr_q), N));

  // A new edge on the channel being acked wins over the clear, and is not an overflow.
  always_comb begin
    ack_fire = (state_q == GRANT) && evt.in_ack;
    clr_vec  = ack_fire ? onehot(gnt_id_q) : '0;
    pend_d   = (pend_q & ~clr_vec) | rise;
    ovf_d    = (in_clr_ovf ? '0 : ovf_q) | (rise & pend_q & ~clr_vec);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      ovf_q    <= '0;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      valid_q  <= 1'b0;
      gnt_q    <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: begin
          if (|pend_q) begin
            state_q  <= GRANT;
            gnt_id_q <= win;
            valid_q  <= 1'b1;
            gnt_q    <= onehot(win);
          end
        end
        GRANT: begin
          if (ack_fire) begin
            state_q  <= IDLE;
            ptr_q    <= (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
            gnt_id_q <= '0;
            valid_q  <= 1'b0;
            gnt_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt.o_valid = valid_q;
  assign evt.o_gnt   = gnt_q;
  assign evt.o_id    = gnt_id_q;
  assign o_pend      = pend_q;
  assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios with literal expectations plus a random run
// checked every cycle against a behavioural model of pending/overflow/round-robin grants.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic         in_clk = 1'b0;
  logic         in_rst;
  logic [N-1:0] in_req;
  logic         in_clr_ovf;
  logic [N-1:0] o_pend, o_ovf;

  edge_event_arbiter_if #(.N(N), .IDW(IDW)) evt ();

  edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_req     (in_req),
    .in_clr_ovf (in_clr_ovf),
    .evt        (evt),
    .o_pend     (o_pend),
    .o_ovf      (o_ovf)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: channel sets, a current grant (-1 when none) and a search pointer.
  bit [N-1:0] m_prev = '1;
  bit [N-1:0] m_pend = '0;
  bit [N-1:0] m_ovf  = '0;
  int         m_gnt  = -1;
  int         m_ptr  = 0;

  always @(posedge in_clk) begin
    bit [N-1:0] r, np, no;
    bit         acked, clearing, found;
    int         c;
    if (in_rst) begin
      m_prev = '1; m_pend = '0; m_ovf = '0; m_gnt = -1; m_ptr = 0;
    end else begin
      acked = (m_gnt >= 0) && evt.in_ack;
      for (int i = 0; i < N; i++) begin
        r[i]     = in_req[i] && !m_prev[i];
        clearing = acked && (m_gnt == i);
        np[i]    = r[i] || (m_pend[i] && !clearing);
        no[i]    = (!in_clr_ovf && m_ovf[i]) || (r[i] && m_pend[i] && !clearing);
      end
      if (m_gnt < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && m_pend[c]) begin
            m_gnt = c;
            found = 1;
          end
        end
      end else if (acked) begin
        m_ptr = (m_gnt + 1) % N;
        m_gnt = -1;
      end
      m_pend = np;
      m_ovf  = no;
      m_prev = in_req;
    end
  end

  always @(negedge in_clk) begin
    if (chk_en) begin
      check("valid", 32'(evt.o_valid), 32'(m_gnt >= 0));
      check("gnt",   32'(evt.o_gnt),   (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
      check("id",    32'(evt.o_id),    (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
      check("pend",  32'(o_pend),      32'(m_pend));
      check("ovf",   32'(o_ovf),       32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wait_grant(output int id);
    bit got;
    got = 0;
    id  = -1;
    for (int i = 0; i < 20; i++) begin
      if (!got && evt.o_valid) begin
        got = 1;
        id  = int'(evt.o_id);
      end
      if (!got) tick();
    end
    if (!got) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_pulse();
    evt.in_ack = 1'b1;
    tick();
    evt.in_ack = 1'b0;
  endtask

  task automatic rise(input logic [N-1:0] mask);
    in_req = '0;
    tick();
    in_req = mask;
    tick();
  endtask

  int order1[4] = '{0, 1, 2, 3};
  int order2[4] = '{3, 0, 1, 2};

  initial begin
    int id;
    in_rst = 1'b1; in_req = 4'b0101; in_clr_ovf = 1'b0; evt.in_ack = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_valid", 32'(evt.o_valid), 32'd0);
    check("rst_pend",  32'(o_pend),      32'd0);
    check("rst_ovf",   32'(o_ovf),       32'd0);
    in_rst = 1'b0;
    repeat (10) tick();
    check("held_high_valid", 32'(evt.o_valid), 32'd0);
    check("held_high_pend",  32'(o_pend),      32'd0);

    rise(4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_grant(id);
      check("rr_order_a", 32'(id), 32'(order1[i]));
      ack_pulse();
    end

    rise(4'b0100);
    check("lat_pend_k",   32'(o_pend),      32'h4);
    check("lat_valid_k",  32'(evt.o_valid), 32'd0);
    tick();
    check("lat_valid_k1", 32'(evt.o_valid), 32'd1);
    check("lat_id_k1",    32'(evt.o_id),    32'd2);
    check("lat_gnt_k1",   32'(evt.o_gnt),   32'h4);
    ack_pulse();
    check("ack_valid",    32'(evt.o_valid), 32'd0);
    check("ack_pend",     32'(o_pend),      32'd0);

    rise(4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_grant(id);
      check("rr_order_b", 32'(id), 32'(order2[i]));
      ack_pulse();
    end

    rise(4'b0010);
    in_req = '0;
    tick();
    check("ovf_grant_id", 32'(evt.o_id), 32'd1);
    in_req = 4'b0010;
    tick();
    check("ovf_set",  32'(o_ovf),  32'h2);
    check("ovf_pend", 32'(o_pend), 32'h2);
    ack_pulse();
    repeat (4) tick();
    check("ovf_single_grant", 32'(evt.o_valid), 32'd0);
    check("ovf_pend_clear",   32'(o_pend),      32'd0);
    in_clr_ovf = 1'b1;
    tick();
    in_clr_ovf = 1'b0;
    check("ovf_clr", 32'(o_ovf), 32'd0);

    rise(4'b0001);
    tick();
    check("same_first_id", 32'(evt.o_id), 32'd0);
    in_req = '0;
    tick();
    in_req = 4'b0001;
    ack_pulse();
    check("same_pend",  32'(o_pend),      32'h1);
    check("same_valid", 32'(evt.o_valid), 32'd0);
    tick();
    check("same_regrant_valid", 32'(evt.o_valid), 32'd1);
    check("same_regrant_id",    32'(evt.o_id),    32'd0);
    ack_pulse();

    rise(4'b1000);
    tick();
    in_req = 4'b1010;
    tick();
    check("mid_id",   32'(evt.o_id), 32'd3);
    check("mid_pend", 32'(o_pend),   32'ha);
    in_rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(evt.o_valid), 32'd0);
    check("mid_rst_gnt",   32'(evt.o_gnt),   32'd0);
    check("mid_rst_pend",  32'(o_pend),      32'd0);
    in_rst = 1'b0;
    repeat (6) tick();
    check("post_rst_idle", 32'(evt.o_valid), 32'd0);
    in_req = 4'b1000;
    tick();
    in_req = 4'b1010;
    tick();
    tick();
    check("post_rst_new_id", 32'(evt.o_id), 32'd1);
    ack_pulse();

    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) in_req[b] = ~in_req[b];
      evt.in_ack = 1'($urandom_range(0, 1));
      in_clr_ovf = ($urandom_range(0, 15) == 0);
      in_rst     = ($urandom_range(0, 299) == 0);
      tick();
    end
    in_rst = 1'b0; evt.in_ack = 1'b0; in_clr_ovf = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Collects rising-edge events from N independent level inputs and shares one downstream event consumer between them. Each channel has its own rising-edge sampler and a sticky pending flag. A round-robin FSM grants one pending channel at a time. The grant is held with a valid/ack handshake until the consumer accepts it. The block sits between the asynchronous-looking status lines (already synchronised upstream) and the single event-servicing datapath.

## Interface
- N, default 4: number of event channels; 2..16.
- IDW, default $clog2(N): width of the channel-ID output.

- in_clk, input, 1: clock; all logic on rising edge.
- in_rst, input, 1: synchronous, active-high reset.
- in_req, input, N: level event lines; a 0→1 transition is one event.
- in_ack, input, 1: consumer accepts the current grant; sampled only while o_valid=1.
- in_clr_ovf, input, 1: clears all o_ovf bits (1-cycle pulse).
- o_valid, output, 1: a grant is being presented.
- o_gnt, output, N: one-hot grant; all zero when o_valid=0.
- o_id, output, IDW: binary index of the granted channel; 0 when o_valid=0.
- o_pend, output, N: current pending flags (registered).
- o_ovf, output, N: sticky per-channel overflow flags.

## Operation
- Edge sampling: prev[i] holds in_req[i] from the previous clock. An event is detected as edge[i] = in_req[i] & ~prev[i].
- Pending set: pending[i] is set at the clock where edge[i]=1.
- Pending clear: pending[i] is cleared at the clock where channel i is granted and in_ack=1.
- Same-cycle edge and ack on the granted channel: set wins, so pending[i] stays 1 and a new event is queued.
- Overflow: edge[i]=1 while pending[i] is already 1 and not being cleared sets ovf[i]. The event is merged and not counted twice.
  - in_clr_ovf clears all ovf bits.
  - If in_clr_ovf and a new overflow occur in the same cycle, the set wins.
- FSM has two states: IDLE and GRANT.
  - IDLE: if any pending bit is set, select a winner by round-robin, latch it as gnt_id, and move to GRANT. Otherwise stay in IDLE.
  - GRANT: o_valid=1, o_gnt=onehot(gnt_id), o_id=gnt_id.
    - in_ack=0: stay in GRANT, outputs stable.
    - in_ack=1: clear pending[gnt_id], set ptr=(gnt_id+1) mod N, go to IDLE.
- Round-robin search: starts at ptr and increments modulo N; the first set pending bit wins. Index wrap from N-1 to 0 is required.
- Arbitration only happens in IDLE. Events arriving during GRANT do not preempt the current grant.
- in_ack received in IDLE is ignored.

## Timing
- Reset values: state=IDLE, ptr=0, pending=0, ovf=0, prev=all ones. With prev reset to all ones, a line already high at reset release is not an event. Outputs after reset: o_valid=0, o_gnt=0, o_id=0, o_pend=0, o_ovf=0.
- Latency, with the first clock sampling in_req[i]=1 (prev=0) as edge k:
  - pending[i]=1 after edge k.
  - FSM enters GRANT after edge k+1.
  - o_valid=1 in the cycle following k+1, i.e. 2 clocks.
- Ack sampled at edge m: o_valid=0 after m. The earliest next grant is valid after m+1, so there is exactly one idle cycle between consecutive grants.
- Throughput: at most one event per 2 clocks.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- in_rst asserted mid-grant: the next clock returns to IDLE with all registers at reset values. The in-flight grant is dropped; no ack is required.

## Structure
- Shared package edge_arb_pkg:
  - state encodings IDLE=1'b0, GRANT=1'b1;
  - a function returning the round-robin winner index given a pending vector and ptr.
- Sub-module rise_sampler (parameter N):
  - holds the prev register;
  - produces the edge vector;
  - implements the reset-to-ones rule.
- Top level holds pending, ovf, ptr, state, gnt_id and the output decode.

## Test plan
- Reset with in_req=4'b0101 held high, release reset, wait 10 clocks -> o_valid stays 0 and o_pend=0.
- in_req[2] pulses 0→1 at edge k -> o_pend=4'b0100 after k; o_valid=1, o_id=2, o_gnt=4'b0100 after k+1; ack at m -> o_valid=0 and o_pend=0 after m.
- Round-robin across all channels:
  - rise all four lines together, ack each grant immediately -> grant order 0,1,2,3;
  - repeat with ptr=3 (last grant was channel 2) -> order 3,0,1,2, exercising wrap.
- Overflow: rise ch1 while it is pending (toggle 1→0→1 before ack) -> o_ovf=4'b0010 and only one grant is issued for ch1; in_clr_ovf pulse -> o_ovf=0.
- Edge on ch0 in the same cycle as the ack of a ch0 grant -> o_pend[0] stays 1 and a second ch0 grant follows 2 clocks later.
- in_rst asserted while o_valid=1 with ch3 granted and ch1 pending -> next clock all outputs 0; no grant after release until a new edge.
